// File: rtl/crossbar_slave_arbiter.sv
// rtl/crossbar_slave_arbiter.sv - round-robin owner arbiter for one crossbar slave port
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   req[COUNT]   per-master request level
//   cmd[COUNT]   per-master command (1=write, 0=read), sampled at grant
//   slave_ack    slave completion strobe
//   grant        one-hot grant, drives the port's muxes/demux
//   grant_idx    index of the granted master
//   busy         port owned (any state other than IDLE)
//   done         one-cycle completion pulse to the owner
//   timeout_err  one-cycle pulse when the slave failed to ack in time
module crossbar_slave_arbiter #(
  parameter  int COUNT   = 2,
  parameter  int TIMEOUT = 255,
  localparam int IW      = (COUNT > 1) ? $clog2(COUNT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [COUNT-1:0] req,
  input  logic [COUNT-1:0] cmd,
  input  logic             slave_ack,
  output logic [COUNT-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             busy,
  output logic [COUNT-1:0] done,
  output logic             timeout_err
);

  // Width 1 when the timeout is disabled so the counter never collapses to zero bits.
  localparam int          TW        = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TCNT_MAX  = '1;
  localparam logic [TW-1:0] TCNT_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, WR_WAIT, RD_WAIT, RD_DATA} state_t;

  state_t           state_q, state_d;
  logic [COUNT-1:0] grant_q, grant_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic [COUNT-1:0] done_q, done_d;
  logic             terr_q, terr_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             lcmd_q, lcmd_d;

  // Winner search: rotate the request vector so bit 0 is the master at ptr,
  // then take the first set bit and map it back to an absolute index.
  logic [2*COUNT-1:0] req_dbl;
  logic [COUNT-1:0]   req_rot;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW:0]        win_sum;
  logic [IW:0]        ptr_inc;
  logic [IW-1:0]      ptr_next;

  always_comb begin
    req_dbl   = {req, req};
    req_rot   = COUNT'(req_dbl >> ptr_q);
    win_found = 1'b0;
    win_idx   = '0;
    win_sum   = '0;
    for (int k = 0; k < COUNT; k++) begin
      if (!win_found && req_rot[k]) begin
        win_found = 1'b1;
        win_sum   = {1'b0, ptr_q} + (IW+1)'(k);
        if (win_sum >= (IW+1)'(COUNT)) win_sum = win_sum - (IW+1)'(COUNT);
        win_idx   = win_sum[IW-1:0];
      end
    end
  end

  // Priority moves to the master just after the one that owned the port.
  always_comb begin
    ptr_inc  = {1'b0, idx_q} + 1'b1;
    ptr_next = (ptr_inc >= (IW+1)'(COUNT)) ? '0 : ptr_inc[IW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= '0;
      terr_q  <= 1'b0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
      lcmd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      terr_q  <= terr_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      lcmd_q  <= lcmd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = '0;
    terr_d  = 1'b0;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    lcmd_d  = lcmd_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d = COUNT'(1) << win_idx;
          idx_d   = win_idx;
          busy_d  = 1'b1;
          lcmd_d  = |(cmd & (COUNT'(1) << win_idx));
          tcnt_d  = '0;
          state_d = (|(cmd & (COUNT'(1) << win_idx))) ? WR_WAIT : RD_WAIT;
        end
      end
      WR_WAIT, RD_WAIT: begin
        if (slave_ack) begin
          if (lcmd_q) begin
            done_d  = COUNT'(1) << idx_q;
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = ptr_next;
            state_d = IDLE;
          end else begin
            state_d = RD_DATA;
          end
        end else if (TIMEOUT > 0 && tcnt_q == TCNT_LAST) begin
          // Forced release: no done pulse, the master sees timeout_err instead.
          terr_d  = 1'b1;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = ptr_next;
          state_d = IDLE;
        end else if (tcnt_q != TCNT_MAX) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      RD_DATA: begin
        // Single cycle for the master to capture rdata; ack here is ignored.
        done_d  = COUNT'(1) << idx_q;
        grant_d = '0;
        busy_d  = 1'b0;
        ptr_d   = ptr_next;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_crossbar_slave_arbiter.sv
// tb/tb_crossbar_slave_arbiter.sv - directed vector bench for crossbar_slave_arbiter
module tb_crossbar_slave_arbiter;

  logic       clk;
  logic       rst;

  logic [1:0] req_a, cmd_a, grant_a, done_a;
  logic       ack_a, busy_a, terr_a;
  logic [0:0] idx_a;

  logic [3:0] req_b, cmd_b, grant_b, done_b;
  logic       ack_b, busy_b, terr_b;
  logic [1:0] idx_b;

  int vec_n  = 0;
  int fail_n = 0;

  crossbar_slave_arbiter #(.COUNT(2), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .req(req_a), .cmd(cmd_a), .slave_ack(ack_a),
    .grant(grant_a), .grant_idx(idx_a), .busy(busy_a), .done(done_a),
    .timeout_err(terr_a)
  );

  crossbar_slave_arbiter #(.COUNT(4), .TIMEOUT(255)) dut_b (
    .clk(clk), .rst(rst), .req(req_b), .cmd(cmd_b), .slave_ack(ack_b),
    .grant(grant_b), .grant_idx(idx_b), .busy(busy_b), .done(done_b),
    .timeout_err(terr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] cmd;
    logic       ack;
    logic [1:0] grant;
    logic       busy;
    logic [1:0] done;
    logic       terr;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [1:0] c, input logic a);
    req_a = r;
    cmd_a = c;
    ack_a = a;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string name, input logic [1:0] g, input logic b,
                         input logic [1:0] d, input logic t);
    check({name, "_grant"}, 32'(grant_a), 32'(g));
    check({name, "_busy"},  32'(busy_a),  32'(b));
    check({name, "_done"},  32'(done_a),  32'(d));
    check({name, "_terr"},  32'(terr_a),  32'(t));
    if (g != 2'b00) check({name, "_idx"}, 32'(idx_a), 32'(g == 2'b10));
  endtask

  initial begin
    // req, cmd, ack | grant, busy, done, terr
    tbl[0]  = '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0};
    tbl[1]  = '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0};
    tbl[2]  = '{2'b01, 2'b01, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0};
    tbl[3]  = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    tbl[4]  = '{2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[5]  = '{2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[6]  = '{2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[7]  = '{2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[8]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0};
    tbl[9]  = '{2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 2'b00, 1'b0};
    tbl[10] = '{2'b11, 2'b11, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0};
    tbl[11] = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0};
    tbl[12] = '{2'b11, 2'b11, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[13] = '{2'b11, 2'b11, 1'b1, 2'b00, 1'b0, 2'b10, 1'b0};
    tbl[14] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};
    tbl[15] = '{2'b01, 2'b01, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0};
    tbl[16] = '{2'b10, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0};
    tbl[17] = '{2'b10, 2'b00, 1'b0, 2'b01, 1'b1, 2'b00, 1'b0};
    tbl[18] = '{2'b10, 2'b00, 1'b1, 2'b00, 1'b0, 2'b01, 1'b0};
    tbl[19] = '{2'b10, 2'b00, 1'b0, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[20] = '{2'b00, 2'b00, 1'b1, 2'b10, 1'b1, 2'b00, 1'b0};
    tbl[21] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b10, 1'b0};
    tbl[22] = '{2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0};

    rst   = 1'b1;
    req_a = '0; cmd_a = '0; ack_a = 1'b0;
    req_b = '0; cmd_b = '0; ack_b = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_a("reset", 2'b00, 1'b0, 2'b00, 1'b0);
    check("reset_idx", 32'(idx_a), 32'd0);
    check("reset_b_grant", 32'(grant_b), 32'd0);
    rst = 1'b0;

    // Round-robin over four always-requesting writers with ack held high.
    req_b = 4'hf; cmd_b = 4'hf; ack_b = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [3:0] exp_g;
      @(posedge clk);
      #1;
      exp_g = 4'b0001 << ((k / 2) % 4);
      if (k % 2 == 0) begin
        check("t3_grant", 32'(grant_b), 32'(exp_g));
        check("t3_idx", 32'(idx_b), 32'((k / 2) % 4));
      end else begin
        check("t3_idle_grant", 32'(grant_b), 32'd0);
        check("t3_idle_busy", 32'(busy_b), 32'd0);
        check("t3_done", 32'(done_b), 32'(4'b0001 << (((k - 1) / 2) % 4)));
      end
    end
    req_b = '0; cmd_b = '0; ack_b = 1'b0;

    // Single write, read with RD_DATA, alternating masters, owner dropping req.
    for (int i = 0; i < 23; i++) begin
      step(tbl[i].req, tbl[i].cmd, tbl[i].ack);
      check_a($sformatf("vec%0d", i), tbl[i].grant, tbl[i].busy, tbl[i].done, tbl[i].terr);
    end

    // Timeout on master 0 write; master 1 waits and is granted afterwards.
    step(2'b01, 2'b01, 1'b0);
    check_a("t4_grant0", 2'b01, 1'b1, 2'b00, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step(2'b10, 2'b10, 1'b0);
      check_a("t4_wait0", 2'b01, 1'b1, 2'b00, 1'b0);
    end
    step(2'b10, 2'b10, 1'b0);
    check_a("t4_timeout", 2'b00, 1'b0, 2'b00, 1'b1);
    step(2'b10, 2'b10, 1'b0);
    check_a("t4_grant1", 2'b10, 1'b1, 2'b00, 1'b0);
    // Ack on the last cycle before the deadline wins over the timeout.
    for (int k = 1; k < 8; k++) begin
      step(2'b00, 2'b00, 1'b0);
      check_a("t4_wait1", 2'b10, 1'b1, 2'b00, 1'b0);
    end
    step(2'b00, 2'b00, 1'b1);
    check_a("t4_late_ack", 2'b00, 1'b0, 2'b10, 1'b0);
    step(2'b00, 2'b00, 1'b0);
    check_a("t4_after", 2'b00, 1'b0, 2'b00, 1'b0);

    // Move ptr to 1, start a read by master 1, then reset mid-cycle.
    step(2'b01, 2'b01, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    check_a("t6_pre_done", 2'b00, 1'b0, 2'b01, 1'b0);
    step(2'b10, 2'b00, 1'b0);
    check_a("t6_rd_wait", 2'b10, 1'b1, 2'b00, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("t6_async_grant", 32'(grant_a), 32'd0);
    check("t6_async_busy", 32'(busy_a), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    // ptr must be back at 0, so master 0 wins a tie.
    step(2'b11, 2'b00, 1'b0);
    check_a("t6_after_rst", 2'b01, 1'b1, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, fail_n);
    $finish;
  end

endmodule
